sort_engine_loader: RTL and testbench

- Upstream feeder for the gnome sort engine.
- Accepts one Avalon-ST packet of unsorted words and clears the engine with a srst pulse.
- Streams the words into the engine's write port, truncating beyond capacity, then issues the run strobe.
- Blocks new input until the engine's sorted output packet has been fully consumed (eop handshake observed).

---
 rtl/sort_engine_pkg.sv | 18 +
 rtl/sort_loader_stats.sv | 25 ++
 rtl/sort_engine_loader.sv | 153 +++++++++++++++
 tb/tb_sort_engine_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_engine_pkg.sv
// Shared types for the sort engine front end.
// Holds the loader state encoding and the capacity helper.
package sort_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DROP,
        RUN,
        WAIT
    } loader_state_t;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sort_loader_stats.sv
// Packet and discarded-beat counters for the sort engine loader.
// Only built when SORT_LOADER_STATS_EN is defined.
module sort_loader_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        drop_i,
    output logic [15:0] pkt_cnt_o,
    output logic [15:0] drop_cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (run_i)
                pkt_cnt_o <= pkt_cnt_o + 16'd1;
            // drop count sticks at all-ones instead of wrapping
            if (drop_i && (drop_cnt_o != 16'hFFFF))
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

endmodule

// File: rtl/sort_engine_loader.sv
// Feeds one Avalon-ST packet into the gnome sort engine and starts it.
// Optional SORT_LOADER_STATS_EN adds packet/drop statistics ports.
module sort_engine_loader
    import sort_engine_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_sop_i,
    input  logic              in_eop_i,
    output logic              in_ready_o,
    output logic              eng_srst_o,
    output logic              eng_wr_req_o,
    output logic [DWIDTH-1:0] eng_wr_data_o,
    output logic              eng_run_o,
    input  logic              eng_pkt_done_i,
    output logic              busy_o,
    output logic [AWIDTH:0]   pkt_len_o,
    output logic              overflow_o
`ifdef SORT_LOADER_STATS_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int DEPTH = depth(AWIDTH);
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1);

    loader_state_t      state_q;
    logic [DWIDTH-1:0]  hold_q;
    logic               hold_eop_q;
    logic [AWIDTH:0]    count_q;
    logic [AWIDTH:0]    cnt_inc;
    logic               accept;

    assign accept    = in_valid_i && in_ready_o;
    assign cnt_inc   = (count_q == DEPTH_C) ? count_q : count_q + ONE_C;
    assign pkt_len_o = count_q;
    assign busy_o    = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_eop_q    <= 1'b0;
            count_q       <= '0;
            in_ready_o    <= 1'b0;
            eng_srst_o    <= 1'b0;
            eng_wr_req_o  <= 1'b0;
            eng_wr_data_o <= '0;
            eng_run_o     <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            eng_srst_o   <= 1'b0;
            eng_wr_req_o <= 1'b0;
            eng_run_o    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && in_sop_i) begin
                        hold_q     <= in_data_i;
                        hold_eop_q <= in_eop_i;
                        eng_srst_o <= 1'b1;
                        overflow_o <= 1'b0;
                        count_q    <= '0;
                        in_ready_o <= 1'b0;
                        state_q    <= CLEAR;
                    end else begin
                        in_ready_o <= 1'b1;
                    end
                end
                CLEAR: begin
                    // first word goes out the cycle after srst
                    eng_wr_req_o  <= 1'b1;
                    eng_wr_data_o <= hold_q;
                    count_q       <= ONE_C;
                    if (hold_eop_q) begin
                        in_ready_o <= 1'b0;
                        state_q    <= RUN;
                    end else if (DEPTH == 1) begin
                        in_ready_o <= 1'b1;
                        overflow_o <= 1'b1;
                        state_q    <= DROP;
                    end else begin
                        in_ready_o <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        eng_wr_req_o  <= 1'b1;
                        eng_wr_data_o <= in_data_i;
                        count_q       <= cnt_inc;
                        if (in_eop_i) begin
                            in_ready_o <= 1'b0;
                            state_q    <= RUN;
                        end else if (cnt_inc == DEPTH_C) begin
                            overflow_o <= 1'b1;
                            state_q    <= DROP;
                        end
                    end
                end
                DROP: begin
                    // nothing left to write, so run follows eop directly
                    if (accept && in_eop_i) begin
                        eng_run_o  <= 1'b1;
                        in_ready_o <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                RUN: begin
                    eng_run_o <= 1'b1;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (eng_pkt_done_i) begin
                        in_ready_o <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    in_ready_o <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

`ifdef SORT_LOADER_STATS_EN
    logic drop_pulse;

    assign drop_pulse = accept &&
                        (((state_q == IDLE) && !in_sop_i) ||
                         (state_q == DROP));

    sort_loader_stats u_stats (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (eng_run_o),
        .drop_i     (drop_pulse),
        .pkt_cnt_o  (pkt_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );
`else
    // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_sort_engine_loader.sv
// Scoreboard bench for sort_engine_loader with a small (AWIDTH=2) engine.
// Define SORT_LOADER_STATS_EN to also check the statistics counters.
module tb_sort_engine_loader;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef logic [DW-1:0] bq_t[$];
    typedef struct {
        int len;
        bit ovf;
    } pkt_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_sop_i;
    logic          in_eop_i;
    logic          in_ready_o;
    logic          eng_srst_o;
    logic          eng_wr_req_o;
    logic [DW-1:0] eng_wr_data_o;
    logic          eng_run_o;
    logic          eng_pkt_done_i;
    logic          busy_o;
    logic [AW:0]   pkt_len_o;
    logic          overflow_o;
`ifdef SORT_LOADER_STATS_EN
    logic [15:0]   pkt_cnt_o;
    logic [15:0]   drop_cnt_o;
`endif

    sort_engine_loader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_sop_i       (in_sop_i),
        .in_eop_i       (in_eop_i),
        .in_ready_o     (in_ready_o),
        .eng_srst_o     (eng_srst_o),
        .eng_wr_req_o   (eng_wr_req_o),
        .eng_wr_data_o  (eng_wr_data_o),
        .eng_run_o      (eng_run_o),
        .eng_pkt_done_i (eng_pkt_done_i),
        .busy_o         (busy_o),
        .pkt_len_o      (pkt_len_o),
        .overflow_o     (overflow_o)
`ifdef SORT_LOADER_STATS_EN
        ,
        .pkt_cnt_o      (pkt_cnt_o),
        .drop_cnt_o     (drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int srst_seen = 0;
    int runs_seen = 0;
    int last_srst_cyc = -1;
    int last_run_cyc = -1;
    int pkts_started = 0;
    int exp_runs = 0;
    int exp_drops = 0;
    logic [DW-1:0] exp_wr[$];
    pkt_t exp_pkt[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor: every write and run pulse is matched against the model.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (eng_srst_o) begin
                srst_seen++;
                last_srst_cyc = cyc;
                check("srst_no_wr", {31'd0, eng_wr_req_o}, 32'd0);
            end
            if (eng_wr_req_o) begin
                if (exp_wr.size() == 0)
                    fail_now("wr_unexpected");
                else
                    check("wr_data", {24'd0, eng_wr_data_o},
                          {24'd0, exp_wr.pop_front()});
            end
            if (eng_run_o) begin
                pkt_t p;
                runs_seen++;
                last_run_cyc = cyc;
                check("run_no_wr", {31'd0, eng_wr_req_o}, 32'd0);
                if (exp_pkt.size() == 0) begin
                    fail_now("run_unexpected");
                end else begin
                    p = exp_pkt.pop_front();
                    check("pkt_len", {29'd0, pkt_len_o}, p.len);
                    check("overflow", {31'd0, overflow_o}, {31'd0, p.ovf});
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit sop,
                             input bit eop, output int t);
        in_data_i  = d;
        in_sop_i   = sop;
        in_eop_i   = eop;
        in_valid_i = 1'b1;
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                t = cyc;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        if (t < 0)
            fail_now("ready_timeout");
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        in_eop_i   = 1'b0;
    endtask

    task automatic send_pkt(input bq_t w);
        int len;
        int t;
        int t_sop;
        int t_eop;
        int rb;
        int lat;
        bit ovf;
        pkt_t p;
        len   = w.size();
        ovf   = (len > DEPTH);
        rb    = runs_seen;
        t_sop = 0;
        t     = 0;
        for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) begin
                eng_pkt_done_i = ($urandom_range(0, 3) == 0);
                @(posedge clk_i);
                #1;
            end
            eng_pkt_done_i = 1'b0;
            send_beat(w[k], (k == 0) || ($urandom_range(0, 7) == 0),
                      k == len - 1, t);
            if (k == 0) begin
                t_sop = t;
                pkts_started++;
            end
            if (k < DEPTH)
                exp_wr.push_back(w[k]);
            else
                exp_drops++;
        end
        t_eop = t;
        p.len = (len < DEPTH) ? len : DEPTH;
        p.ovf = ovf;
        exp_pkt.push_back(p);
        for (int i = 0; i < 20; i++) begin
            if (runs_seen != rb)
                break;
            @(posedge clk_i);
        end
        #1;
        if (runs_seen == rb) begin
            fail_now("run_timeout");
            return;
        end
        exp_runs++;
        lat = (len == 1) ? 3 : (ovf ? 1 : 2);
        check("srst_lat", last_srst_cyc, t_sop + 1);
        check("run_lat", last_run_cyc, t_eop + lat);
        // A new sop is held off until the engine reports its eop.
        in_data_i  = 8'($urandom);
        in_sop_i   = 1'b1;
        in_eop_i   = 1'b0;
        in_valid_i = 1'b1;
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk_i);
            check("wait_ready", {31'd0, in_ready_o}, 32'd0);
            check("wait_busy", {31'd0, busy_o}, 32'd1);
            @(posedge clk_i);
            #1;
        end
        eng_pkt_done_i = 1'b1;
        @(negedge clk_i);
        check("done_ready", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        eng_pkt_done_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", {31'd0, in_ready_o}, 32'd1);
        check("idle_busy", {31'd0, busy_o}, 32'd0);
        #1;
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    function automatic bq_t rand_pkt(input int len);
        bq_t q;
        for (int i = 0; i < len; i++)
            q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic logic [31:0] out_vec();
        return {15'd0, in_ready_o, eng_srst_o, eng_wr_req_o, eng_wr_data_o,
                eng_run_o, busy_o, pkt_len_o, overflow_o};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bq_t q;
        int t;
        rst_i          = 1'b1;
        in_data_i      = '0;
        in_valid_i     = 1'b0;
        in_sop_i       = 1'b0;
        in_eop_i       = 1'b0;
        eng_pkt_done_i = 1'b0;
        #2;
        check("reset_outs", out_vec(), 32'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        q = {8'h05, 8'h01, 8'h09};
        send_pkt(q);
        q = {8'h7A};
        send_pkt(q);
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(q);

        send_beat(8'h11, 1'b0, 1'b0, t);
        exp_drops++;
        send_beat(8'h22, 1'b0, 1'b1, t);
        exp_drops++;
        send_pkt(rand_pkt(3));

        for (int n = 0; n < 25; n++)
            send_pkt(rand_pkt($urandom_range(1, 7)));

`ifdef SORT_LOADER_STATS_EN
        check("pkt_cnt", {16'd0, pkt_cnt_o}, exp_runs);
        check("drop_cnt", {16'd0, drop_cnt_o}, exp_drops);
`endif

        // Abort a packet after two words with an asynchronous reset.
        send_beat(8'hA5, 1'b1, 1'b0, t);
        exp_wr.push_back(8'hA5);
        pkts_started++;
        send_beat(8'h5A, 1'b0, 1'b0, t);
        exp_wr.push_back(8'h5A);
        repeat (3) @(posedge clk_i);
        #1;
        check("wr_drained", exp_wr.size(), 32'd0);
        check("abort_len", {29'd0, pkt_len_o}, 32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        check("reset_mid_load", out_vec(), 32'd0);
`ifdef SORT_LOADER_STATS_EN
        check("reset_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd0);
`endif
        exp_wr.delete();
        exp_pkt.delete();
        exp_runs  = 0;
        exp_drops = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        send_pkt(rand_pkt(2));
        send_pkt(rand_pkt(5));

        check("srst_count", srst_seen, pkts_started);
        check("wr_left", exp_wr.size(), 32'd0);
        check("pkt_left", exp_pkt.size(), 32'd0);
`ifdef SORT_LOADER_STATS_EN
        check("pkt_cnt_end", {16'd0, pkt_cnt_o}, exp_runs);
        check("drop_cnt_end", {16'd0, drop_cnt_o}, exp_drops);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
